// File: rtl/md_unit.sv
// md_unit: multicycle multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU compute their result at launch into hold registers,
// then the unit stays busy for a fixed number of cycles before HI/LO commit.
// MTHI/MTLO write HI/LO directly in a single cycle while idle; MFHI/MFLO
// read the architectural registers through the combinational MDOut port.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut
);

  // Counter is wide enough for the longer latency, never narrower than 4 bits.
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W_RAW  = $clog2(MAX_CYCLES + 32'sd1);
  localparam int CNT_W      = (CNT_W_RAW < 32'sd4) ? 32'sd4 : CNT_W_RAW;

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  // A zero-cycle latency would never leave BUSY correctly, so clamp to 1.
  localparam logic [CNT_W-1:0] MULT_LOAD =
    (MULT_CYCLES < 32'sd1) ? CNT_ONE : CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD =
    (DIV_CYCLES < 32'sd1) ? CNT_ONE : CNT_W'(DIV_CYCLES);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // True for the four opcodes that launch a multicycle operation.
  function automatic logic is_md_op(input logic [3:0] op);
    return (op >= OP_MULT) && (op <= OP_DIVU);
  endfunction

  // Two's-complement magnitude of a 32-bit value (0x80000000 maps to itself,
  // which is the correct unsigned magnitude 2^31).
  function automatic logic [31:0] magnitude(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [31:0]      hold_hi_q, hold_hi_d;
  logic [31:0]      hold_lo_q, hold_lo_d;
  logic             hold_wr_q, hold_wr_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic             start_ok;
  logic             op_is_div;
  logic             done;
  logic [63:0]      prod_signed;
  logic [63:0]      prod_unsigned;
  logic [31:0]      a_mag, b_mag, b_mag_safe, b_raw_safe;
  logic [31:0]      mag_quot, mag_rem;
  logic [31:0]      uns_quot, uns_rem;
  logic [31:0]      sgn_quot, sgn_rem;
  logic             div_by_zero;

  // Launch qualification and completion detection.
  always_comb begin
    start_ok  = (state_q == ST_IDLE) && Start && is_md_op(MDOp);
    op_is_div = (MDOp == OP_DIV) || (MDOp == OP_DIVU);
    done      = (state_q == ST_BUSY) && (cnt_q <= CNT_ONE);
  end

  // Arithmetic on the operands presented in the launch cycle.
  always_comb begin
    // Low 64 bits of the product of sign-extended operands equal the signed product.
    prod_signed   = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_unsigned = {32'd0, A} * {32'd0, B};

    // Divisor forced to 1 on zero so the divider never sees x/0; the result
    // is discarded in that case anyway.
    div_by_zero = (B == 32'd0);
    b_raw_safe  = div_by_zero ? 32'd1 : B;
    uns_quot    = A / b_raw_safe;
    uns_rem     = A % b_raw_safe;

    // Signed division through magnitudes: quotient truncates toward zero and
    // the remainder takes the sign of the dividend. 0x80000000 / -1 falls out
    // naturally as 0x80000000 with remainder 0.
    a_mag      = magnitude(A);
    b_mag      = magnitude(B);
    b_mag_safe = div_by_zero ? 32'd1 : b_mag;
    mag_quot   = a_mag / b_mag_safe;
    mag_rem    = a_mag % b_mag_safe;
    sgn_quot   = (A[31] ^ B[31]) ? (32'd0 - mag_quot) : mag_quot;
    sgn_rem    = A[31] ? (32'd0 - mag_rem) : mag_rem;
  end

  // FSM next-state and busy down-counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = ST_BUSY;
          cnt_d   = op_is_div ? DIV_LOAD : MULT_LOAD;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = cnt_q;
        end
      end
      ST_BUSY: begin
        if (cnt_q <= CNT_ONE) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_BUSY;
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // FSM outputs: registered Busy follows the next state; MDOut reads HI/LO.
  always_comb begin
    busy_d = (state_d == ST_BUSY);
    case (MDOp)
      OP_MFHI: MDOut = hi_q;
      OP_MFLO: MDOut = lo_q;
      default: MDOut = 32'd0;
    endcase
  end

  // State register, counter and Busy flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Datapath next values: capture results at launch, commit at completion,
  // direct MTHI/MTLO writes only when idle and no launch is requested.
  always_comb begin
    hold_hi_d = hold_hi_q;
    hold_lo_d = hold_lo_q;
    hold_wr_d = hold_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (start_ok) begin
      case (MDOp)
        OP_MULT: begin
          hold_hi_d = prod_signed[63:32];
          hold_lo_d = prod_signed[31:0];
          hold_wr_d = 1'b1;
        end
        OP_MULTU: begin
          hold_hi_d = prod_unsigned[63:32];
          hold_lo_d = prod_unsigned[31:0];
          hold_wr_d = 1'b1;
        end
        OP_DIV: begin
          hold_hi_d = sgn_rem;
          hold_lo_d = sgn_quot;
          hold_wr_d = !div_by_zero;
        end
        OP_DIVU: begin
          hold_hi_d = uns_rem;
          hold_lo_d = uns_quot;
          hold_wr_d = !div_by_zero;
        end
        default: begin
          hold_wr_d = 1'b0;
        end
      endcase
    end else if (done) begin
      if (hold_wr_q) begin
        hi_d = hold_hi_q;
        lo_d = hold_lo_q;
      end else begin
        hi_d = hi_q;
        lo_d = lo_q;
      end
    end else if ((state_q == ST_IDLE) && !Start) begin
      case (MDOp)
        OP_MTHI: hi_d = A;
        OP_MTLO: lo_d = A;
        default: begin
          hi_d = hi_q;
          lo_d = lo_q;
        end
      endcase
    end else begin
      hi_d = hi_q;
      lo_d = lo_q;
    end
  end

  // Hold registers and architectural HI/LO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_hi_q <= 32'd0;
      hold_lo_q <= 32'd0;
      hold_wr_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      hold_hi_q <= hold_hi_d;
      hold_lo_q <= hold_lo_d;
      hold_wr_q <= hold_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5: Busy duration for MULT/MULTU.
REQ-002 Parameter DIV_CYCLES, default 10: Busy duration for DIV/DIVU.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 Start  input  1  E-stage pulse; launches a MULT/MULTU/DIV/DIVU op.
REQ-006 MDOp  input  4  op code: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, 9-15 NONE.
REQ-007 A  input  32  operand rs (forwarded E-stage value).
REQ-008 B  input  32  operand rt (forwarded E-stage value).
REQ-009 Busy  output  1  registered; high while an op is in flight.
REQ-010 HI  output  32  architectural HI register.
REQ-011 LO  output  32  architectural LO register.
REQ-012 MDOut  output  32  combinational read port: HI if MDOp=7, LO if MDOp=8, else 0.

Function
REQ-013 Two-state FSM: IDLE (Busy=0), BUSY (Busy=1); down-counter cnt, 4 bits min, sized to max(MULT_CYCLES, DIV_CYCLES).
REQ-014 IDLE, Start=1, MDOp in 1..4 at edge T: compute result from A/B sampled at T into internal hold regs; cnt<=N (MULT_CYCLES for 1/2, DIV_CYCLES for 3/4); go BUSY.
REQ-015 Busy rises after edge T and stays high exactly N cycles; falls at edge T+N.
REQ-016 HI/LO load hold regs at edge T+N (same edge Busy falls); HI/LO unchanged during BUSY.
REQ-017 MULT: {HI,LO}=signed A * signed B, 64-bit product; MULTU: unsigned 64-bit product.
REQ-018 DIV: LO=signed quotient truncated toward zero, HI=signed remainder with sign of A; DIVU: unsigned quotient/remainder.
REQ-019 DIV/DIVU with B=0: op runs full DIV_CYCLES, Busy behaves normally, HI/LO left unchanged at completion.
REQ-020 DIV with A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0; no trap.
REQ-021 MTHI (5), Start=0, IDLE: HI<=A at next edge; MTLO (6): LO<=A; single-cycle, Busy stays 0.
REQ-022 Start=1 while BUSY: ignored, in-flight op unaffected (upstream stall logic guarantees it does not occur; RTL still ignores it).
REQ-023 MTHI/MTLO while BUSY: ignored.
REQ-024 Start=1 with MDOp not in 1..4: ignored, no state change.
REQ-025 Start=1 with MDOp in 1..4 and simultaneous MTHI/MTLO impossible by encoding; Start takes precedence over MDOp 5/6 interpretation.
REQ-026 Back-to-back: Start at edge T+N (Busy falling) not accepted; earliest accepted Start at edge T+N+1 (first IDLE cycle after completion).
REQ-027 MDOut reads current HI/LO registers, not in-flight hold regs.

Reset
REQ-028 reset=1 forces immediately, clock-independent: state=IDLE, Busy=0, cnt=0, HI=0, LO=0, hold regs=0.
REQ-029 reset during BUSY aborts op; no HI/LO update after reset deasserts.
REQ-030 First Start honoured at first rising edge with reset=0.

Verification
REQ-031 MULT A=0xFFFFFFFE(-2), B=3, Start at edge T -> Busy=1 for 5 cycles, at T+5 HI=0xFFFFFFFF, LO=0xFFFFFFFA, Busy=0.
REQ-032 MULTU A=0xFFFFFFFF, B=2 -> at T+5 HI=0x00000001, LO=0xFFFFFFFE.
REQ-033 DIV A=-7 (0xFFFFFFF9), B=2 -> Busy 10 cycles, at T+10 LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7,B=0 after MTHI/MTLO of 0x11/0x22 -> HI=0x11, LO=0x22 after 10 cycles.
REQ-034 MTLO A=0x1234 in IDLE -> LO=0x1234 next edge, Busy=0; MDOp=8 -> MDOut=0x1234; MTHI during BUSY -> HI unchanged.
REQ-035 Start MULT then reset asserted mid-cycle 3 -> Busy, HI, LO drop to 0 immediately; no update at would-be T+5.
REQ-036 Start DIV, second Start MULT at T+4 -> ignored; DIV result at T+10; Start at T+11 accepted, Busy through T+16.
